// File: rtl/data_memory_pkg.sv
// Shared widths and types for the 16-bit CPU data memory.
package data_memory_pkg;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam int BYTE_W = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/data_memory.sv
// Byte-addressed, big-endian word memory for the MEM stage (word-aligned access).
// Optional build macro DMEM_READ_REG_EN registers ReadData (1-cycle latency).
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_BYTES = 128
) (
    input  logic  Clock,
    input  logic  Reset,
    input  word_t WD,
    input  addr_t Adresa,
    input  logic  MemWrite,
    input  logic  MemRead,
    output word_t ReadData
);
    localparam int IDX_W = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;

    if ((DEPTH_BYTES % 2) != 0 || DEPTH_BYTES < 2 || DEPTH_BYTES > 65536) begin : g_bad_depth
        $error("data_memory: DEPTH_BYTES must be even and in 2..65536");
    end

    byte_t             mem_q [DEPTH_BYTES];
    logic [ADDR_W:0]   odd_addr;
    logic              in_range;
    logic [IDX_W-1:0]  even_idx;
    logic [IDX_W-1:0]  odd_idx;
    word_t             rd_word_d;
    logic              unused_addr_lsb;

    // Range is judged on the odd (last) byte of the pair, with one spare bit so 65536 fits.
    assign odd_addr        = {1'b0, Adresa[ADDR_W-1:1], 1'b1};
    assign in_range        = odd_addr < (ADDR_W+1)'(DEPTH_BYTES);
    assign even_idx        = {Adresa[IDX_W-1:1], 1'b0};
    assign odd_idx         = {Adresa[IDX_W-1:1], 1'b1};
    assign unused_addr_lsb = Adresa[0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemWrite && in_range) begin
            mem_q[even_idx] <= WD[15:8];
            mem_q[odd_idx]  <= WD[7:0];
        end
    end

    always_comb begin
        rd_word_d = '0;
        if (MemRead && in_range) begin
            rd_word_d = {mem_q[even_idx], mem_q[odd_idx]};
        end
    end

`ifdef DMEM_READ_REG_EN
    word_t rdata_q;

    // Captures pre-write contents: a same-edge write shows up one cycle later.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rd_word_d;
        end
    end

    assign ReadData = rdata_q;
`else
    assign ReadData = rd_word_d;
`endif
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory using an expected-value queue and a byte model.
module tb_data_memory;
    localparam int DEPTH = 128;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] WD;
    logic [15:0] Adresa;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] ReadData;

    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    logic [7:0]  mdl [DEPTH];
    int          checks = 0;
    int          errors = 0;

    data_memory #(.DEPTH_BYTES(DEPTH)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .WD       (WD),
        .Adresa   (Adresa),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        Adresa = a; WD = d; MemWrite = 1'b1; MemRead = 1'b0;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [15:0] d);
        int ev;
        ev = {a[15:1], 1'b0};
        if (ev + 1 < DEPTH) begin
            mdl[ev]     = d[15:8];
            mdl[ev + 1] = d[7:0];
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a, input logic rd);
        int ev;
        ev = {a[15:1], 1'b0};
        if (!rd || ev + 1 >= DEPTH) return 16'h0000;
        return {mdl[ev], mdl[ev + 1]};
    endfunction

    task automatic test_reset();
        Reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; WD = '0; Adresa = '0;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
        MemRead = 1'b1; Adresa = 16'd10;
        exp_q.push_back(16'h0000);
`ifdef DMEM_READ_REG_EN
        tick();
`else
        #1;
`endif
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL reset_read got %h expected %h", ReadData, exp_v);
        end
    endtask

`ifdef DMEM_READ_REG_EN
    task automatic test_reg_latency();
        do_write(16'd10, 16'h1234);
        MemRead = 1'b1; Adresa = 16'd10;
        exp_q.push_back(16'h0000);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL reg_before_edge got %h expected %h", ReadData, exp_v);
        end
        exp_q.push_back(16'h1234);
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL reg_after_edge got %h expected %h", ReadData, exp_v);
        end
        MemWrite = 1'b1; WD = 16'hBEEF;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hBEEF);
        tick();
        MemWrite = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL reg_same_edge_write got %h expected %h", ReadData, exp_v);
        end
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL reg_next_edge got %h expected %h", ReadData, exp_v);
        end
        MemRead = 1'b0;
        exp_q.push_back(16'h0000);
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL reg_read_gate got %h expected %h", ReadData, exp_v);
        end
    endtask
`else
    task automatic test_write_read();
        logic [15:0] addrs [3] = '{16'd10, 16'd11, 16'd10};
        logic        rds   [3] = '{1'b1, 1'b1, 1'b0};
        do_write(16'd10, 16'h1234); model_write(16'd10, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            Adresa = addrs[i]; MemRead = rds[i];
            exp_q.push_back(model_read(addrs[i], rds[i]));
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (ReadData !== exp_v) begin
                errors++; $display("FAIL write_read[%0d] addr %0d got %h expected %h", i, addrs[i], ReadData, exp_v);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] addrs [4] = '{16'(DEPTH), 16'd0, 16'(DEPTH - 2), 16'(DEPTH - 1)};
        logic [15:0] exps  [4] = '{16'h0000, 16'h0000, 16'hC3A5, 16'hC3A5};
        do_write(16'(DEPTH), 16'hABCD);
        do_write(16'(DEPTH - 2), 16'hC3A5); model_write(16'(DEPTH - 2), 16'hC3A5);
        MemRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Adresa = addrs[i];
            exp_q.push_back(exps[i]);
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (ReadData !== exp_v) begin
                errors++; $display("FAIL range[%0d] addr %0d got %h expected %h", i, addrs[i], ReadData, exp_v);
            end
        end
    endtask

    task automatic test_read_during_write();
        do_write(16'd20, 16'h1111);
        Adresa = 16'd20; WD = 16'h5A5A; MemRead = 1'b1; MemWrite = 1'b1;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h5A5A);
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL rdw_before got %h expected %h", ReadData, exp_v);
        end
        tick();
        exp_v = exp_q.pop_front(); checks++;
        if (ReadData !== exp_v) begin
            errors++; $display("FAIL rdw_after got %h expected %h", ReadData, exp_v);
        end
        MemWrite = 1'b0;
        model_write(16'd20, 16'h5A5A);
    endtask

    task automatic test_reset_priority();
        logic [15:0] addrs [3] = '{16'd10, 16'd20, 16'(DEPTH - 2)};
        Adresa = 16'd10; WD = 16'hFFFF; MemWrite = 1'b1; Reset = 1'b1; MemRead = 1'b0;
        tick();
        Reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            Adresa = addrs[i];
            exp_q.push_back(16'h0000);
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (ReadData !== exp_v) begin
                errors++; $display("FAIL reset_prio addr %0d got %h expected %h", addrs[i], ReadData, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, d;
        logic        rd;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(0, DEPTH + 31));
            d = 16'($urandom);
            do_write(a, d);
            model_write(a, d);
        end
        for (int i = 0; i < 20; i++) begin
            a  = 16'($urandom_range(0, DEPTH + 31));
            rd = (i % 5) != 4;
            Adresa = a; MemRead = rd;
            exp_q.push_back(model_read(a, rd));
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (ReadData !== exp_v) begin
                errors++; $display("FAIL b2b[%0d] addr %0d got %h expected %h", i, a, ReadData, exp_v);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DMEM_READ_REG_EN
        test_reg_latency();
`else
        test_write_read();
        test_out_of_range();
        test_read_during_write();
        test_reset_priority();
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
